// File: rtl/instr_fetch_aligner.sv
// Fetch-side instruction aligner: buffers up to two fetched words and presents whole
// instructions to decode. Define RVC_EN to enable 16-bit compressed parcel alignment.
module instr_fetch_aligner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        instr_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        compressed_inst_o,
  output logic        illegal_compressed_inst_o
);

`ifdef RVC_EN
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif
  localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;
  localparam logic [1:0]  FIFO_DEPTH = 2'd2;

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] w0_q, w0_d, w1_q, w1_d;
  logic [1:0]  cnt_q, cnt_d, cnt_tmp;
  logic        outstanding_q, outstanding_d;
  logic        discard_q, discard_d;

  logic        avail, is_comp, ill_c;
  logic [31:0] instr_c, pc_step, pc_seq, jump_pc;
  logic        fetch_hs, consume, pop, push;

  // Instruction extraction from the head of the buffer at the current pc
`ifdef RVC_EN
  logic [15:0] lo;
  assign lo      = pc_q[1] ? w0_q[31:16] : w0_q[15:0];
  assign is_comp = (lo[1:0] != 2'b11);
  assign avail   = (is_comp || !pc_q[1]) ? (cnt_q != 2'd0) : (cnt_q == FIFO_DEPTH);
  assign instr_c = is_comp ? {16'h0000, lo}
                           : (pc_q[1] ? {w1_q[15:0], w0_q[31:16]} : w0_q);
  assign ill_c   = is_comp && (lo == 16'h0000);
  assign pc_step = is_comp ? 32'd2 : 32'd4;
`else
  assign is_comp = 1'b0;
  assign avail   = (cnt_q != 2'd0);
  assign instr_c = w0_q;
  assign ill_c   = (w0_q[1:0] != 2'b11);
  assign pc_step = 32'd4;
`endif

  assign instr_valid_o             = avail && !jump_i;
  assign instr_o                   = avail ? instr_c : 32'h0;
  assign pc_o                      = pc_q;
  assign compressed_inst_o         = avail && is_comp;
  assign illegal_compressed_inst_o = avail && ill_c;

  // Request depends on registered state only (rst_i gating keeps it low during reset)
  assign instr_req_o  = !rst_i && !outstanding_q && (cnt_q < FIFO_DEPTH);
  assign instr_addr_o = fetch_addr_q;

  assign fetch_hs = instr_req_o && instr_gnt_i;
  assign consume  = instr_valid_o && instr_ready_i;
  assign pc_seq   = pc_q + pc_step;
  assign pop      = consume && (pc_seq[31:2] != pc_q[31:2]);
  assign push     = instr_rvalid_i && !discard_q;
  assign jump_pc  = jump_target_i & PC_MASK;

  always_comb begin
    pc_d          = pc_q;
    fetch_addr_d  = fetch_addr_q;
    w0_d          = w0_q;
    w1_d          = w1_q;
    cnt_tmp       = cnt_q;
    cnt_d         = cnt_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (instr_rvalid_i) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
    end
    if (fetch_hs) begin
      outstanding_d = 1'b1;
      fetch_addr_d  = fetch_addr_q + 32'd4;
    end

    if (consume) pc_d = pc_seq;
    if (pop) begin
      w0_d    = w1_q;
      cnt_tmp = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_tmp == 2'd0) w0_d = instr_rdata_i;
      else                 w1_d = instr_rdata_i;
      cnt_tmp = cnt_tmp + 2'd1;
    end
    cnt_d = cnt_tmp;

    // Redirect wins; a request granted this cycle carried the old address, so drop it too
    if (jump_i) begin
      pc_d         = jump_pc;
      fetch_addr_d = jump_pc & WORD_MASK;
      cnt_d        = 2'd0;
      discard_d    = (outstanding_q && !instr_rvalid_i) || fetch_hs;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= BOOT_ADDR & PC_MASK;
      fetch_addr_q  <= BOOT_ADDR & WORD_MASK;
      w0_q          <= 32'h0;
      w1_q          <= 32'h0;
      cnt_q         <= 2'd0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fetch_addr_q  <= fetch_addr_d;
      w0_q          <= w0_d;
      w1_q          <= w1_d;
      cnt_q         <= cnt_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_aligner.sv
// Self-checking bench for instr_fetch_aligner: memory responder plus an instruction-stream
// reference model computed from a memory image and a program counter.
`timescale 1ns/1ps
module tb_instr_fetch_aligner;

  localparam logic [31:0] BOOT = 32'h0000_0100;
`ifdef RVC_EN
  localparam logic [31:0] PCMASK = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] PCMASK = 32'hFFFF_FFFC;
`endif

  logic        clk = 1'b0;
  logic        rst_i, instr_req_o, instr_gnt_i, instr_rvalid_i, jump_i, instr_ready_i;
  logic        instr_valid_o, compressed_inst_o, illegal_compressed_inst_o;
  logic [31:0] instr_addr_o, instr_rdata_i, jump_target_i, instr_o, pc_o;

  always #5 clk = ~clk;

  instr_fetch_aligner #(.BOOT_ADDR(BOOT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i), .instr_ready_i(instr_ready_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .compressed_inst_o(compressed_inst_o),
    .illegal_compressed_inst_o(illegal_compressed_inst_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] m_pc;
  logic [31:0] got_pc[$], got_ins[$];
  logic        got_c[$], got_ill[$];

  logic        pend;
  logic [31:0] pend_addr;
  int          pend_wait, lat_min, lat_max, gnt_pct, hs_count;
  logic        hs_last;
  logic [31:0] hs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] k;
    k = a & 32'hFFFF_FFFC;
    if (mem.exists(k)) return mem[k];
    return (k * 32'h9E37_79B1) + 32'h0123_4567;
  endfunction

  // Expected instruction at a pc, straight from the memory image
  task automatic model_at(input logic [31:0] pc, output logic [31:0] ins, output logic c,
                          output logic ill, output logic [31:0] step);
`ifdef RVC_EN
    logic [31:0] w, w2;
    logic [15:0] h, h2;
    w  = word_at(pc);
    h  = pc[1] ? w[31:16] : w[15:0];
    w2 = word_at(pc + 32'd2);
    h2 = pc[1] ? w2[15:0] : w2[31:16];
    if (h[1:0] != 2'b11) begin
      ins = {16'h0000, h}; c = 1'b1; ill = (h == 16'h0000); step = 32'd2;
    end else begin
      ins = {h2, h}; c = 1'b0; ill = 1'b0; step = 32'd4;
    end
`else
    ins  = word_at(pc);
    c    = 1'b0;
    ill  = (ins[1:0] != 2'b11);
    step = 32'd4;
`endif
  endtask

  // One clock cycle: check any consume against the model, then run the memory responder
  task automatic tick();
    logic        hs;
    logic [31:0] a, e_ins, step;
    logic        e_c, e_ill;
    #4;
    hs = instr_req_o && instr_gnt_i && !rst_i;
    a  = instr_addr_o;
    if (!rst_i && jump_i) begin
      chk("valid_in_jump", 32'(instr_valid_o), 32'd0);
      m_pc = jump_target_i & PCMASK;
    end else if (!rst_i && instr_valid_o && instr_ready_i) begin
      model_at(m_pc, e_ins, e_c, e_ill, step);
      chk("pc", pc_o, m_pc);
      chk("instr", instr_o, e_ins);
      chk("compressed", 32'(compressed_inst_o), 32'(e_c));
      chk("illegal", 32'(illegal_compressed_inst_o), 32'(e_ill));
      got_pc.push_back(pc_o);
      got_ins.push_back(instr_o);
      got_c.push_back(compressed_inst_o);
      got_ill.push_back(illegal_compressed_inst_o);
      m_pc = m_pc + step;
    end
    if (hs) begin
      chk("addr_aligned", 32'(a[1:0]), 32'd0);
      chk("single_outstanding", 32'(pend), 32'd0);
      hs_count++;
    end
    hs_last = hs;
    hs_addr = a;
    @(posedge clk);
    #1;
    instr_rvalid_i = 1'b0;
    if (rst_i) pend = 1'b0;
    else if (hs) begin
      pend      = 1'b1;
      pend_addr = a;
      pend_wait = int'($urandom_range(lat_max, lat_min));
    end
    if (pend) begin
      if (pend_wait == 0) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = word_at(pend_addr);
        pend           = 1'b0;
      end else pend_wait--;
    end
    instr_gnt_i = (int'($urandom_range(99, 0)) < gnt_pct);
    jump_i      = 1'b0;
  endtask

  task automatic do_jump(input logic [31:0] t);
    got_pc.delete(); got_ins.delete(); got_c.delete(); got_ill.delete();
    jump_i        = 1'b1;
    jump_target_i = t;
    tick();
  endtask

  task automatic run_consumes(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (got_pc.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(got_pc.size() >= n), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    int          h0, k, n_cons;
    rst_i = 1'b1; instr_gnt_i = 1'b1; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
    jump_i = 1'b0; jump_target_i = 32'h0; instr_ready_i = 1'b0;
    pend = 1'b0; pend_addr = 32'h0; pend_wait = 0; lat_min = 0; lat_max = 0;
    gnt_pct = 100; hs_count = 0; hs_last = 1'b0; hs_addr = 32'h0; m_pc = BOOT & PCMASK;
    mem[32'h100] = 32'h0050_0093;
    mem[32'h108] = 32'hDEAD_BEE3;
    mem[32'h300] = 32'h00A0_0113;

    // Reset values and start-up latency
    tick(); tick();
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_addr", instr_addr_o, 32'h100);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h100);
    chk("rst_c", 32'(compressed_inst_o), 32'd0);
    chk("rst_ill", 32'(illegal_compressed_inst_o), 32'd0);
    rst_i = 1'b0;
    #1;
    chk("c1_req", 32'(instr_req_o), 32'd1);
    chk("c1_addr", instr_addr_o, 32'h100);
    tick();
    chk("c2_valid", 32'(instr_valid_o), 32'd0);
    tick();
    chk("c3_valid", 32'(instr_valid_o), 32'd1);
    chk("c3_instr", instr_o, 32'h0050_0093);
    chk("c3_pc", pc_o, 32'h100);
    chk("c3_c", 32'(compressed_inst_o), 32'd0);

    // Stalled decode: buffer fills to two words, request drops, output holds
    held = instr_o;
    h0   = hs_count;
    repeat (20) tick();
    chk("stall_req", 32'(instr_req_o), 32'd0);
    chk("stall_fetches", 32'(hs_count - h0), 32'd1);
    chk("stall_valid", 32'(instr_valid_o), 32'd1);
    chk("stall_hold", instr_o, held);

    // Redirect while the 0x108 fetch is in flight; its late response must be dropped
    instr_ready_i = 1'b1;
    lat_min = 1; lat_max = 1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!(hs_last && hs_addr == 32'h108) && k < 60);
    chk("saw_fetch_108", 32'(hs_last && hs_addr == 32'h108), 32'd1);
    do_jump(32'h300);
    run_consumes(1, 30, "jump_300_timeout");
    chk("jump_pc", got_pc[0], 32'h300);
    chk("jump_instr", got_ins[0], 32'h00A0_0113);
    lat_min = 0; lat_max = 0;

`ifdef RVC_EN
    mem[32'h100] = 32'h0001_4501;
    do_jump(32'h100);
    run_consumes(3, 40, "rvc_seq_timeout");
    chk("rvc0_pc", got_pc[0], 32'h100);
    chk("rvc0_instr", got_ins[0], 32'h0000_4501);
    chk("rvc0_c", 32'(got_c[0]), 32'd1);
    chk("rvc1_pc", got_pc[1], 32'h102);
    chk("rvc1_instr", got_ins[1], 32'h0000_0001);
    chk("rvc1_c", 32'(got_c[1]), 32'd1);
    chk("rvc2_pc", got_pc[2], 32'h104);

    mem[32'h200] = 32'h0093_4501;
    mem[32'h204] = 32'h0000_0050;
    do_jump(32'h202);
    run_consumes(2, 40, "split_timeout");
    chk("split_pc", got_pc[0], 32'h202);
    chk("split_instr", got_ins[0], 32'h0050_0093);
    chk("split_c", 32'(got_c[0]), 32'd0);
    chk("split_next_pc", got_pc[1], 32'h206);

    mem[32'h400] = 32'h0000_0000;
    do_jump(32'h400);
    run_consumes(1, 30, "ill_timeout");
    chk("ill_pc", got_pc[0], 32'h400);
    chk("ill_instr", got_ins[0], 32'h0);
    chk("ill_c", 32'(got_c[0]), 32'd1);
    chk("ill_flag", 32'(got_ill[0]), 32'd1);
`else
    mem[32'h500] = 32'h1234_5601;
    do_jump(32'h500);
    run_consumes(1, 30, "ill_timeout");
    chk("ill_instr", got_ins[0], 32'h1234_5601);
    chk("ill_c", 32'(got_c[0]), 32'd0);
    chk("ill_flag", 32'(got_ill[0]), 32'd1);
`endif

    // Randomized traffic: grant/latency/ready jitter, random redirects, one mid-run reset
    for (int a = 32'h1000; a < 32'h1400; a += 4) mem[32'(a)] = $urandom;
    gnt_pct = 70; lat_min = 0; lat_max = 3;
    do_jump(32'h1000);
    n_cons = 0;
    for (int i = 0; i < 3000; i++) begin
      instr_ready_i = (int'($urandom_range(3, 0)) != 0);
      if (i == 1500) begin
        rst_i = 1'b1;
        tick();
        chk("valid_after_reset", 32'(instr_valid_o), 32'd0);
        chk("pc_after_reset", pc_o, BOOT & PCMASK);
        rst_i = 1'b0;
        m_pc  = BOOT & PCMASK;
        got_pc.delete();
      end else if ($urandom_range(63, 0) == 0) begin
        n_cons += got_pc.size();
        do_jump(32'h1000 + (32'($urandom_range(511, 0)) << 1));
      end else tick();
    end
    n_cons += got_pc.size();
    chk("random_progress", 32'(n_cons > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
